// File: rtl/axis_deadlock_monitor.sv
// Deadlock monitor: qualifies AXIS/sub-instance block conditions over THRESHOLD cycles and records the first cause.
// Latency: block rises THRESHOLD+1 edges after raw goes high and falls 1 edge after raw goes low.
// Backpressure: none; this is a passive observer with no flow control.
module axis_deadlock_monitor #(
    parameter int NUM_AXIS = 8,
    parameter int NUM_SUB = 3,
    parameter int SUB_EN = 0,
    parameter int THRESHOLD = 0,
    parameter int CNT_W = 8,
    parameter logic [NUM_AXIS-1:0] CHAN_MASK = '1,
    localparam int CHW = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_SUB-1:0]  inst_idle_sigs,
    input  logic [NUM_SUB-1:0]  inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                block_sticky,
    output logic                first_src,
    output logic [CHW-1:0]      first_chan,
    output logic [CNT_W-1:0]    event_count
);

    localparam int RW = (THRESHOLD > 0) ? $clog2(THRESHOLD + 1) : 1;
    localparam logic [RW-1:0] THR = RW'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, PEND, BLOCKED} state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       run_cnt, cnt_nxt;
    logic [NUM_AXIS-1:0] masked;
    logic                axis_hit, sub_hit, raw, rise;
    logic [CHW-1:0]      low_chan;

    assign masked   = axis_block_sigs & CHAN_MASK;
    assign axis_hit = |masked;
    assign sub_hit  = (SUB_EN != 0) && (&(inst_block_sigs | inst_idle_sigs)) && (|inst_block_sigs);
    assign raw      = axis_hit | sub_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= cnt_nxt;
        end
    end

    // run_cnt saturates at THR, so once it matches the condition is qualified.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = run_cnt;
        if (!raw) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (run_cnt == THR) begin
            state_nxt = BLOCKED;
        end else begin
            state_nxt = PEND;
            cnt_nxt   = run_cnt + 1'b1;
        end
    end

    always_comb begin
        block = (state == BLOCKED);
        rise  = (state_nxt == BLOCKED) && (state != BLOCKED);
    end

    always_comb begin
        low_chan = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (masked[i]) low_chan = CHW'(i);
        end
    end

    // A rise coinciding with clear still loads a fresh capture and a count of one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block_sticky <= 1'b0;
            first_src    <= 1'b0;
            first_chan   <= '0;
            event_count  <= '0;
        end else if (rise) begin
            block_sticky <= 1'b1;
            if (!block_sticky || clear) begin
                first_src  <= !axis_hit;
                first_chan <= low_chan;
            end
            if (clear)
                event_count <= CNT_W'(1);
            else if (event_count != CNT_MAX)
                event_count <= event_count + 1'b1;
        end else if (clear) begin
            block_sticky <= 1'b0;
            first_src    <= 1'b0;
            first_chan   <= '0;
            event_count  <= '0;
        end
    end

endmodule

// File: doc/axis_deadlock_monitor.md
# axis_deadlock_monitor

Parametrised deadlock monitor for one dataflow process instance in the PFB co-simulation harness. It watches a configurable number of AXI-Stream block signals and the block/idle status of sub-instances. It asserts `block` only after the blocking condition has persisted for a programmable number of cycles. It also keeps a sticky flag, the first blocking source, and a saturating event count for the deadlock reporter.

## Interface
- `NUM_AXIS`, 8: number of AXIS block inputs monitored (≥1).
- `NUM_SUB`, 3: number of sub-instances (≥1).
- `SUB_EN`, 0: 1 = sub-instance aggregation contributes to the block condition.
- `THRESHOLD`, 0: extra consecutive cycles the condition must hold before `block` asserts (0 = one-cycle registered behaviour).
- `CNT_W`, 8: width of `event_count`.
- `CHAN_MASK`, all ones: per-channel enable mask, NUM_AXIS bits.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `axis_block_sigs`  in  NUM_AXIS  per-channel AXIS block indication.
- `inst_idle_sigs`  in  NUM_SUB  sub-instance idle.
- `inst_block_sigs`  in  NUM_SUB  sub-instance blocked.
- `clear`  in  1  synchronous clear of sticky/capture/count state.
- `block`  out  1  registered, qualified block indication.
- `block_sticky`  out  1  set on any `block` rise, held until `clear`.
- `first_src`  out  1  0 = AXIS channel, 1 = sub-instances; valid when `block_sticky`.
- `first_chan`  out  max(1,$clog2(NUM_AXIS))  lowest-index blocking AXIS channel at first capture.
- `event_count`  out  CNT_W  saturating count of `block` rising edges.

## Operation
- `axis_hit = |(axis_block_sigs & CHAN_MASK)`.
- `sub_hit = SUB_EN & (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs)`.
  - Every sub-instance must be blocked or idle, and at least one must be blocked.
- `raw = axis_hit | sub_hit`. This is combinational and never used unregistered at an output.
- Run counter `run_cnt`, width max(1,$clog2(THRESHOLD+1)). Behaviour at each edge:
  - raw=0: `run_cnt`←0 and `block`←0.
  - raw=1 and `run_cnt`<THRESHOLD: `run_cnt`++ and `block`←0.
  - raw=1 and `run_cnt`==THRESHOLD: `block`←1 and `run_cnt` holds.
  - `run_cnt` never exceeds THRESHOLD, so it cannot wrap.
- The counter implements three states: IDLE (run_cnt=0, block=0), PEND (counting, block=0) and BLOCKED (block=1).
  - IDLE→PEND or BLOCKED when raw=1.
  - Any state→IDLE when raw=0.
- Rise event: the edge at which `block` goes 0→1.
- Capture rules:
  - On a rise event with `block_sticky`=0, `first_src`←(axis_hit?0:1). AXIS has priority when both are hit.
  - On that same event, `first_chan`←index of the lowest set bit of masked `axis_block_sigs`, or 0 if none is set.
  - Later rises do not update the capture until `clear`.
- `event_count` increments on each rise event and saturates at 2^CNT_W−1.
- `clear`:
  - Zeroes `block_sticky`, `first_src`, `first_chan` and `event_count`.
  - Does not affect `run_cnt` or `block`.
  - If `clear` coincides with a rise event, the rise wins: sticky=1, capture loaded, count=1.
- A reset mid-run drops `block` immediately and discards the partial run.

## Timing
- All outputs are registered. Reset value of every output is 0. `run_cnt` resets to 0.
- `block` latency: THRESHOLD+1 rising edges after raw first sampled high, with raw held high continuously.
- `block` deasserts on the first edge raw is sampled low (1-cycle latency).
- A single-cycle raw glitch of length ≤THRESHOLD produces no `block` and no event.
- `block_sticky`, capture and `event_count` update on the same edge as the `block` rise.
- Deassertion of `reset_n` is treated as asynchronous. The first active edge is the one after release.

## Test plan
- Default params (THRESHOLD=0), pulse `axis_block_sigs[5]` for 1 cycle → `block`=1 for exactly 1 cycle, one cycle later; `first_chan`=5, `first_src`=0, `event_count`=1.
- THRESHOLD=4, hold bit 2 for 4 cycles then drop → `block` never asserts and `event_count`=0. Hold for 5 cycles → `block` rises at the 5th edge and `event_count`=1.
- SUB_EN=1, NUM_SUB=3:
  - block=3'b001, idle=3'b110 → `block` asserts, `first_src`=1.
  - block=3'b001, idle=3'b010 → no assertion.
  - block=0, idle=3'b111 → no assertion.
- Bits 6 and 3 asserted together → `first_chan`=3. A later rise on bit 1 alone → `first_chan` stays 3 and `event_count`=2. Pulse `clear` → all capture outputs read 0.
- CNT_W=2, produce 5 separate rise events → `event_count` saturates at 3. Assert `clear` on the same edge as a rise → sticky=1, count=1.
- Assert `reset_n`=0 mid-PEND and mid-BLOCKED, asynchronously between edges → all outputs 0 immediately. After release, the full THRESHOLD+1 latency is required again. Also set CHAN_MASK bit 0 = 0 and drive bit 0 → no block.
